// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Imported by the fetch queue and its prefetch FIFO.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory and decode handshakes around fetch_queue.
// master is the fetch stage side; slave is the memory/decode side.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            instr_mem_req_o;
  logic [XLEN-1:0] instr_mem_addr_o;
  logic            instr_mem_gnt_i;
  logic            instr_mem_rvalid_i;
  logic [XLEN-1:0] instr_mem_rd_data_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;

  modport master (
    output instr_mem_req_o, instr_mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  instr_mem_gnt_i, instr_mem_rvalid_i, instr_mem_rd_data_i,
           redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  instr_mem_req_o, instr_mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output instr_mem_gnt_i, instr_mem_rvalid_i, instr_mem_rd_data_i,
           redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous show-ahead FIFO: head is valid whenever count is non-zero.
// clear empties the FIFO and wins over a same-cycle push or pop.
module fetch_fifo import fetch_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned CW      = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop) && !clear;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// RV32I fetch stage: owns the PC, issues credit-limited pipelined memory requests,
// buffers in-order responses with their PC and flushes on a redirect.
module fetch_queue import fetch_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            instr_mem_req_o,
  output logic [XLEN-1:0] instr_mem_addr_o,
  input  logic            instr_mem_gnt_i,
  input  logic            instr_mem_rvalid_i,
  input  logic [XLEN-1:0] instr_mem_rd_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int unsigned   CW        = cnt_width(DEPTH);
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_pc_aligned;
  logic            req, fire, rsp_ok, push, pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    push_entry, head_entry;

  // Requests in flight plus buffered entries never exceed DEPTH, so every response has a slot.
  assign credit_used         = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req                 = !reset && !redirect_i && (credit_used < DEPTH_LIM);
  assign fire                = req && instr_mem_gnt_i;
  assign rsp_ok              = instr_mem_rvalid_i && (outstanding_q != '0);
  assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    push          = 1'b0;
    outstanding_d = outstanding_q + CW'(fire) - CW'(rsp_ok);
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      // Everything still in flight belongs to the old path; a response landing now is already gone.
      drop_cnt_d = outstanding_q - CW'(rsp_ok);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_ok) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + PC_STEP;
        end
      end
    end
  end

  assign pop = !fifo_empty && instr_ready_i && !redirect_i;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = resp_pc_q;
    push_entry.instr = instr_mem_rd_data_i;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t),
    .CW      (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign instr_mem_req_o  = req;
  assign instr_mem_addr_o = fetch_pc_q;
  assign instr_valid_o    = !fifo_empty;
  // An empty queue presents a NOP at the reset PC rather than stale FIFO contents.
  assign instr_o          = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign instr_pc_o       = fifo_empty ? RESET_PC  : head_entry.pc;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a 1-cycle memory model answers granted
// addresses in order; granted PCs are queued as expectations and compared at decode.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_mem_req_o     (bus.instr_mem_req_o),
    .instr_mem_addr_o    (bus.instr_mem_addr_o),
    .instr_mem_gnt_i     (bus.instr_mem_gnt_i),
    .instr_mem_rvalid_i  (bus.instr_mem_rvalid_i),
    .instr_mem_rd_data_i (bus.instr_mem_rd_data_i),
    .redirect_i          (bus.redirect_i),
    .redirect_pc_i       (bus.redirect_pc_i),
    .instr_valid_o       (bus.instr_valid_o),
    .instr_o             (bus.instr_o),
    .instr_pc_o          (bus.instr_pc_o),
    .instr_ready_i       (bus.instr_ready_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic        gnt_en, ready_en, mem_on, redir;
  logic [31:0] redir_pc;
  logic [31:0] resp_q [$];
  logic [31:0] exp_q  [$];
  logic [31:0] exp_fetch_pc;

  logic        s_req, s_valid, s_fire, s_acc, s_rsp;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // One clock cycle: drive at the falling edge, sample 2 time units later, then take the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    bus.instr_mem_gnt_i = gnt_en;
    bus.instr_ready_i   = ready_en;
    bus.redirect_i      = redir;
    bus.redirect_pc_i   = redir_pc;
    s_rsp = mem_on && (resp_q.size() > 0);
    bus.instr_mem_rvalid_i  = s_rsp;
    bus.instr_mem_rd_data_i = s_rsp ? tag_of(resp_q[0]) : 32'h0;
    #2;
    s_req   = bus.instr_mem_req_o;
    s_addr  = bus.instr_mem_addr_o;
    s_valid = bus.instr_valid_o;
    s_pc    = bus.instr_pc_o;
    s_instr = bus.instr_o;
    s_fire  = !reset && s_req && gnt_en;
    s_acc   = !reset && s_valid && ready_en && !redir;
    if (reset) check("req_in_reset", s_req, 0);
    if (redir) check("req_in_redirect", s_req, 0);
    if (s_acc) begin
      if (exp_q.size() == 0) check("spurious_valid", s_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("head_pc", s_pc, e);
        check("head_instr", s_instr, tag_of(e));
      end
    end
    if (s_fire) begin
      check("issue_addr", s_addr, exp_fetch_pc);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      resp_q.push_back(s_addr);
      exp_q.push_back(s_addr);
    end
    if (redir) begin
      exp_q.delete();
      exp_fetch_pc = redir_pc & ~32'h3;
    end
    if (reset) begin
      exp_q.delete();
      exp_fetch_pc = RESET_PC;
    end
    @(posedge clk);
    if (s_rsp) void'(resp_q.pop_front());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_first(input string tag, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (s_acc) begin
        seen = 1'b1;
        check(tag, s_pc, exp_pc);
      end
    end
    if (!seen) check({tag, "_timeout"}, s_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] addrs [3];
    int          n_addr;

    reset = 1'b1; gnt_en = 1'b0; ready_en = 1'b0; mem_on = 1'b1;
    redir = 1'b0; redir_pc = '0; exp_fetch_pc = RESET_PC;

    // Reset values
    ticks(2);
    check("rst_req", s_req, 0);
    check("rst_addr", s_addr, RESET_PC);
    check("rst_valid", s_valid, 0);
    check("rst_instr", s_instr, NOP);
    check("rst_pc", s_pc, RESET_PC);

    // Streaming with single-cycle memory and decode always ready
    reset = 1'b0; gnt_en = 1'b1; ready_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        check("first_req", s_req, 1);
        check("first_addr", s_addr, RESET_PC);
      end
      check("stream_valid", s_valid, (i >= 3));
    end

    // Back-pressure: issue stops once the credit budget is used
    ready_en = 1'b0;
    ticks(8);
    check("fill_req_low", s_req, 0);
    check("fill_depth", exp_q.size(), 4);
    check("fill_head_pc", s_pc, exp_q[0]);
    ready_en = 1'b1;
    tick();
    tick();
    check("resume_req", s_req, 1);

    // Redirect with three responses outstanding
    gnt_en = 1'b0;
    ticks(8);
    mem_on = 1'b0; gnt_en = 1'b1;
    ticks(3);
    gnt_en = 1'b0;
    check("outstanding3", resp_q.size(), 3);
    redir = 1'b1; redir_pc = 32'h0000_0100;
    tick();
    redir = 1'b0; gnt_en = 1'b1;
    tick();
    check("redir_req", s_req, 1);
    check("redir_addr", s_addr, 32'h0000_0100);
    mem_on = 1'b1;
    wait_first("redir_first_pc", 32'h0000_0100);
    ticks(6);

    // Redirect coinciding with a response and a decode pop
    redir = 1'b1; redir_pc = 32'h0000_0202;
    tick();
    check("collide_setup", s_rsp && s_valid, 1);
    redir = 1'b0;
    tick();
    check("collide_flushed", s_valid, 0);
    wait_first("collide_first_pc", 32'h0000_0200);
    ticks(4);

    // Address wrap at the top of the space
    redir = 1'b1; redir_pc = 32'hFFFF_FFFA;
    tick();
    redir = 1'b0;
    n_addr = 0;
    for (int i = 0; i < 10 && n_addr < 3; i++) begin
      tick();
      if (s_fire) begin
        addrs[n_addr] = s_addr;
        n_addr++;
      end
    end
    check("wrap_count", n_addr, 3);
    check("wrap_a0", addrs[0], 32'hFFFF_FFF8);
    check("wrap_a1", addrs[1], 32'hFFFF_FFFC);
    check("wrap_a2", addrs[2], 32'h0000_0000);
    ticks(6);

    // Reset mid-operation with buffered entries and responses in flight
    gnt_en = 1'b0;
    ticks(6);
    ready_en = 1'b0; gnt_en = 1'b1; mem_on = 1'b1;
    ticks(3);
    mem_on = 1'b0;
    ticks(2);
    check("midrst_req_low", s_req, 0);
    check("midrst_outstanding", resp_q.size(), 2);
    check("midrst_valid", s_valid, 1);
    reset = 1'b1; gnt_en = 1'b0;
    tick();
    reset = 1'b0; mem_on = 1'b1;
    tick();
    check("postrst_valid", s_valid, 0);
    check("postrst_instr", s_instr, NOP);
    check("postrst_pc", s_pc, RESET_PC);
    check("postrst_addr", s_addr, RESET_PC);
    tick();
    check("stray1_ignored", s_valid, 0);
    tick();
    check("stray2_ignored", s_valid, 0);
    gnt_en = 1'b1; ready_en = 1'b1;
    wait_first("restart_pc", RESET_PC);
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
